// File: rtl/ttl_74356_param_if.sv
// rtl/ttl_74356_param_if.sv - select/enable/data inputs and registered outputs of the clocked data selector
interface ttl_74356_param_if #(
   parameter int WIDTH_IN = 8
);
   localparam int WIDTH_SELECT = $clog2(WIDTH_IN);

   logic                    Enable_bar;
   logic                    Load_bar;
   logic [WIDTH_SELECT-1:0] Select;
   logic [WIDTH_IN-1:0]     D;
   logic                    Y;
   logic                    Y_bar;
   logic                    Select_Error;

   // Driver side: supplies controls and data, observes the registered outputs.
   modport master (
      output Enable_bar, Load_bar, Select, D,
      input  Y, Y_bar, Select_Error
   );

   // Selector side.
   modport slave (
      input  Enable_bar, Load_bar, Select, D,
      output Y, Y_bar, Select_Error
   );
endinterface

// File: rtl/ttl_74356_param.sv
// rtl/ttl_74356_param.sv - clocked parametrised data selector; optional D input register via TTL_74356_DATA_REG_EN
module ttl_74356_param #(
   parameter int WIDTH_IN   = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input logic               Clk,
   input logic               Clear_bar,
   ttl_74356_param_if.slave  bus
);
   localparam int WIDTH_SELECT = $clog2(WIDTH_IN);

   // The rise/fall delays describe the timing of the physical part; the
   // registers themselves are zero-delay, so only sanity-check the values.
   if (WIDTH_IN < 2 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
      $error("ttl_74356_param: WIDTH_IN must be >= 2 and delays non-negative");
   end

   logic [WIDTH_SELECT-1:0] s_reg;
   logic                    q;
   logic                    err;
   logic [WIDTH_IN-1:0]     dsrc;
   logic                    sel_bit;
   logic                    s_out_of_range;

`ifdef TTL_74356_DATA_REG_EN
   logic [WIDTH_IN-1:0] d_reg;

   // Data input register: adds one edge of D-to-Y latency, cleared with the rest.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         d_reg <= '0;
      end else begin
         d_reg <= bus.D;
      end
   end

   assign dsrc = d_reg;
`else
   assign dsrc = bus.D;
`endif

   // Range check done at 32 bits so it stays meaningful for any WIDTH_IN.
   assign s_out_of_range = (int'(s_reg) >= WIDTH_IN);

   // Mux by explicit compare so select codes past WIDTH_IN never index out of range.
   always_comb begin
      sel_bit = 1'b0;
      for (int i = 0; i < WIDTH_IN; i++) begin
         if (s_reg == WIDTH_SELECT'(i)) begin
            sel_bit = dsrc[i];
         end
      end
   end

   // Select register, error flag and output register; Q and Err use the pre-edge S_reg.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         s_reg <= '0;
         q     <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (!bus.Load_bar) begin
            s_reg <= bus.Select;
         end
         err <= s_out_of_range;
         q   <= (bus.Enable_bar || s_out_of_range) ? 1'b0 : sel_bit;
      end
   end

   assign bus.Y            = q;
   assign bus.Y_bar        = ~q;
   assign bus.Select_Error = err;
endmodule

// File: tb/tb_ttl_74356_param.sv
// tb/tb_ttl_74356_param.sv - directed self-checking bench for ttl_74356_param (WIDTH_IN=5)
module tb_ttl_74356_param;
   logic clk;
   logic clear_bar;
   int   total;
   int   bad;

   ttl_74356_param_if #(.WIDTH_IN(5)) bus ();

   ttl_74356_param #(
      .WIDTH_IN   (5),
      .DELAY_RISE (5),
      .DELAY_FALL (3)
   ) dut (
      .Clk       (clk),
      .Clear_bar (clear_bar),
      .bus       (bus)
   );

   // 20-unit clock, rising edges at 10, 30, 50, ...
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land 10 after it (on the falling edge).
   task automatic step();
      @(posedge clk);
      #10;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear_bar      = 1'b0;
      bus.Enable_bar = 1'b1;
      bus.Load_bar   = 1'b1;
      bus.Select     = 3'b000;
      bus.D          = 5'b00000;
      step();
      step();
      check("reset_y", bus.Y, 1'b0);
      check("reset_ybar", bus.Y_bar, 1'b1);
      check("reset_err", bus.Select_Error, 1'b0);

      // Select latency: load 3 with D=01010.
      clear_bar      = 1'b1;
      bus.Enable_bar = 1'b0;
      bus.Load_bar   = 1'b0;
      bus.Select     = 3'b011;
      bus.D          = 5'b01010;
      step();
      check("sel_lat_edge1_y", bus.Y, 1'b0);
      bus.Load_bar = 1'b1;
      bus.Select   = 3'b000;
      step();
      check("sel_lat_edge2_y", bus.Y, 1'b1);
      check("sel_lat_edge2_ybar", bus.Y_bar, 1'b0);

      // Hold with Load_bar high, then enable off and back on.
      step();
      check("hold1_y", bus.Y, 1'b1);
      step();
      check("hold2_y", bus.Y, 1'b1);
      step();
      check("hold3_y", bus.Y, 1'b1);
      bus.Enable_bar = 1'b1;
      step();
      check("disable_y", bus.Y, 1'b0);
      check("disable_ybar", bus.Y_bar, 1'b1);
      bus.Enable_bar = 1'b0;
      step();
      check("reenable_y", bus.Y, 1'b1);

      // Out of range select 6.
      bus.Load_bar = 1'b0;
      bus.Select   = 3'b110;
      bus.D        = 5'b11111;
      step();
      bus.Load_bar = 1'b1;
      step();
      check("oor_y", bus.Y, 1'b0);
      check("oor_ybar", bus.Y_bar, 1'b1);
      check("oor_err", bus.Select_Error, 1'b1);
      check("oor_no_x", $isunknown({bus.Y, bus.Y_bar, bus.Select_Error}), 1'b0);
      bus.Load_bar = 1'b0;
      bus.Select   = 3'b010;
      step();
      check("recover_edge1_err", bus.Select_Error, 1'b1);
      check("recover_edge1_y", bus.Y, 1'b0);
      bus.Load_bar = 1'b1;
      step();
      check("recover_edge2_y", bus.Y, 1'b1);
      check("recover_edge2_err", bus.Select_Error, 1'b0);

      // Data latency with S_reg=3.
      bus.Load_bar = 1'b0;
      bus.Select   = 3'b011;
      bus.D        = 5'b01010;
      step();
      bus.Load_bar = 1'b1;
      step();
      check("dlat_pre_y", bus.Y, 1'b1);
      bus.D = 5'b00010;
      step();
`ifdef TTL_74356_DATA_REG_EN
      check("dlat_edge1_y", bus.Y, 1'b1);
      step();
      check("dlat_edge2_y", bus.Y, 1'b0);
`else
      check("dlat_edge1_y", bus.Y, 1'b0);
`endif

      // Clear mid-run with S_reg=4, Y=1.
      bus.Load_bar = 1'b0;
      bus.Select   = 3'b100;
      bus.D        = 5'b10000;
      step();
      bus.Load_bar = 1'b1;
      step();
      check("preclear_y", bus.Y, 1'b1);
      clear_bar = 1'b0;
      #3;
      check("clear_async_y", bus.Y, 1'b0);
      check("clear_async_ybar", bus.Y_bar, 1'b1);
      check("clear_async_err", bus.Select_Error, 1'b0);
      #2;
      clear_bar = 1'b1;
      bus.D     = 5'b00001;
      step();
`ifdef TTL_74356_DATA_REG_EN
      check("postclear_edge1_y", bus.Y, 1'b0);
      step();
`endif
      check("postclear_y", bus.Y, 1'b1);
      check("postclear_ybar", bus.Y_bar, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
